griffin_sched: RTL and testbench

//  Shares one Griffin permutation core among NUM_REQ requesters with round-robin arbitration.
//  Per job: grants one requester and collects STATE_SIZE field words over valid/ready.

---
 rtl/griffin_pkg.sv | 15 +
 rtl/griffin_sched_if.sv | 25 ++
 rtl/griffin_sched_rr_arbiter.sv | 28 ++
 rtl/griffin_sched.sv | 170 +++++++++++++++++
 tb/tb_griffin_sched.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/griffin_pkg.sv
// Shared types and defaults for the Griffin permutation scheduler.
package griffin_pkg;
   localparam int N_BITS_DEF     = 254;
   localparam int STATE_SIZE_DEF = 3;

   typedef logic [N_BITS_DEF-1:0] field_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      RUN    = 3'd3,
      UNLOAD = 3'd4
   } sched_state_e;
endpackage

// File: rtl/griffin_sched_if.sv
// Requester-side and response-side handshake bundle of the Griffin scheduler.
interface griffin_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int N_BITS  = 254,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][N_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [N_BITS-1:0]              rsp_data;
   logic [ID_W-1:0]                rsp_id;
   logic                           rsp_last;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_last
   );
endinterface

// File: rtl/griffin_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclically.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);
   logic        found;
   int unsigned idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end
endmodule

// File: rtl/griffin_sched.sv
// Shares one Griffin permutation core among NUM_REQ requesters: load state,
// run the core under a watchdog, stream the result back tagged with the id.
module griffin_sched
   import griffin_pkg::*;
#(
   parameter int N_BITS     = N_BITS_DEF,
   parameter int STATE_SIZE = STATE_SIZE_DEF,
   parameter int NUM_REQ    = 4,
   parameter int MAX_CYCLES = 1024,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                                clk,
   input  logic                                reset_n,
   griffin_sched_if.slave                      bus,
   output logic [STATE_SIZE-1:0][N_BITS-1:0]   core_in,
   output logic                                core_reset,
   output logic                                core_enable,
   input  logic [STATE_SIZE-1:0][N_BITS-1:0]   core_out,
   input  logic                                core_done,
   output logic                                busy,
   output logic                                err_timeout
);
   localparam int WCNT_W = $clog2(STATE_SIZE + 1);
   localparam int RUN_W  = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] S_IDLE   = 3'(IDLE);
   localparam logic [2:0] S_LOAD   = 3'(LOAD);
   localparam logic [2:0] S_START  = 3'(START);
   localparam logic [2:0] S_RUN    = 3'(RUN);
   localparam logic [2:0] S_UNLOAD = 3'(UNLOAD);

   logic [2:0]                          state_q, state_d;
   logic [ID_W-1:0]                     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]                     grant_id_q, grant_id_d;
   logic [WCNT_W-1:0]                   wcnt_q, wcnt_d;
   logic [WCNT_W-1:0]                   rcnt_q, rcnt_d;
   logic [RUN_W-1:0]                    run_cnt_q, run_cnt_d;
   logic [STATE_SIZE-1:0][N_BITS-1:0]   words_q, words_d;
   logic [STATE_SIZE-1:0][N_BITS-1:0]   result_q, result_d;

   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    arb_id;
   logic               sel_valid;
   logic [N_BITS-1:0]  sel_data;
   logic               run_expired;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req      (bus.req_valid),
      .ptr      (rr_ptr_q),
      .grant    (arb_grant),
      .grant_id (arb_id)
   );

   // Only the locked-in requester is visible while loading.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == ID_W'(i)) begin
            sel_valid = bus.req_valid[i];
            sel_data  = bus.req_data[i];
         end
      end
   end

   assign run_expired = (run_cnt_q == RUN_W'(MAX_CYCLES - 1));

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      run_cnt_d  = run_cnt_q;
      words_d    = words_q;
      result_d   = result_q;
      case (state_q)
         S_IDLE: begin
            if (|arb_grant) begin
               grant_id_d = arb_id;
               wcnt_d     = '0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (sel_valid) begin
               for (int i = 0; i < STATE_SIZE; i++) begin
                  if (wcnt_q == WCNT_W'(i)) words_d[i] = sel_data;
               end
               wcnt_d = wcnt_q + WCNT_W'(1);
               if (wcnt_q == WCNT_W'(STATE_SIZE - 1)) begin
                  rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
                  wcnt_d   = '0;
                  state_d  = S_START;
               end
            end
         end
         S_START: begin
            run_cnt_d = '0;
            state_d   = S_RUN;
         end
         S_RUN: begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
            // A done arriving on the expiry cycle still wins over the watchdog.
            if (core_done) begin
               result_d = core_out;
               rcnt_d   = '0;
               state_d  = S_UNLOAD;
            end else if (run_expired) begin
               state_d = S_IDLE;
            end
         end
         S_UNLOAD: begin
            if (bus.rsp_ready) begin
               rcnt_d = rcnt_q + WCNT_W'(1);
               if (rcnt_q == WCNT_W'(STATE_SIZE - 1)) begin
                  rcnt_d  = '0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         run_cnt_q  <= '0;
         words_q    <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
         run_cnt_q  <= run_cnt_d;
         words_q    <= words_d;
         result_q   <= result_d;
      end
   end

   // All outputs decode from registered state, so reset reaches them asynchronously.
   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_ready[i] = (state_q == S_LOAD) && (grant_id_q == ID_W'(i));
      end
      bus.rsp_valid = (state_q == S_UNLOAD);
      bus.rsp_data  = '0;
      if (state_q == S_UNLOAD) begin
         for (int i = 0; i < STATE_SIZE; i++) begin
            if (rcnt_q == WCNT_W'(i)) bus.rsp_data = result_q[i];
         end
      end
      bus.rsp_id   = (state_q == S_UNLOAD) ? grant_id_q : '0;
      bus.rsp_last = (state_q == S_UNLOAD) && (rcnt_q == WCNT_W'(STATE_SIZE - 1));
      core_reset   = (state_q == S_IDLE) || (state_q == S_START);
      core_enable  = (state_q == S_RUN);
      busy         = (state_q != S_IDLE);
      err_timeout  = (state_q == S_RUN) && !core_done && run_expired;
   end

   assign core_in = words_q;
endmodule

// File: tb/tb_griffin_sched.sv
// Randomized bench for griffin_sched with a job-level reference model.
module tb_griffin_sched;
   localparam int NB   = 254;
   localparam int SS   = 3;
   localparam int NR   = 4;
   localparam int MAXC = 40;
   localparam int IDW  = 2;

   typedef logic [NB-1:0] word_t;
   typedef struct {
      word_t data;
      int    id;
      bit    last;
      int    idx;
   } rsp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   griffin_sched_if #(.NUM_REQ(NR), .N_BITS(NB), .ID_W(IDW)) bus ();
   logic [SS-1:0][NB-1:0] core_in, core_out;
   logic core_reset, core_enable, core_done, busy, err_timeout;

   griffin_sched #(.N_BITS(NB), .STATE_SIZE(SS), .NUM_REQ(NR), .MAX_CYCLES(MAXC)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .core_in     (core_in),
      .core_reset  (core_reset),
      .core_enable (core_enable),
      .core_out    (core_out),
      .core_done   (core_done),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   // Core stand-in: result word = input word + 6, done after done_delay enabled cycles.
   int unsigned run_cnt_m = 0;
   int unsigned done_delay = 5;
   bit          no_done = 1'b0;
   always @(posedge clk) begin
      if (core_reset) run_cnt_m <= 0;
      else if (core_enable) run_cnt_m <= run_cnt_m + 1;
   end
   assign core_done = core_enable && !no_done && (run_cnt_m + 1 >= done_delay);
   always_comb begin
      for (int i = 0; i < SS; i++) core_out[i] = core_in[i] + NB'(6);
   end

   word_t req_q [NR][$];
   word_t load_w [$];
   rsp_t  exp_q [$];
   rsp_t  rsp_log [$];
   int    grant_log [$];
   int    ptr_m, exp_grant, load_id, rsp_mode, bp_hold, start_chk, err_cnt, gap_mode;
   bit    grant_pend, m_load, gap_tog, prev_hold, expect_idle;
   word_t prev_data;
   logic [IDW-1:0] prev_id;
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic word_t rnd_w();
      logic [255:0] t;
      for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
      return t[NB-1:0];
   endfunction

   function automatic int pick(input logic [NR-1:0] v, input int p);
      for (int i = 0; i < NR; i++) begin
         if (v[(p + i) % NR]) return (p + i) % NR;
      end
      return -1;
   endfunction

   task automatic push_job(input int r, input bit directed);
      for (int i = 0; i < SS; i++) req_q[r].push_back(directed ? word_t'(i + 1) : rnd_w());
   endtask

   task automatic clear_model();
      exp_q.delete();
      load_w.delete();
      m_load = 0; grant_pend = 0; ptr_m = 0; prev_hold = 0;
      start_chk = 0; expect_idle = 0; bp_hold = 0;
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_core_enable", core_enable, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_last", bus.rsp_last, 0);
      chk("rst_err", err_timeout, 0);
      chk("rst_core_in", |core_in, 0);
      clear_model();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic cycle();
      logic [NR-1:0] oh;
      int g;
      rsp_t e;
      @(negedge clk);
      chk("ready_onehot0", $onehot0(bus.req_ready), 1);
      if (grant_pend) begin
         grant_pend = 0;
         oh = '0; oh[exp_grant] = 1'b1;
         chk("grant", bus.req_ready, oh);
         grant_log.push_back(exp_grant);
         load_id = exp_grant;
         m_load = 1;
      end
      if (m_load) chk("load_core_ctl", {core_reset, core_enable}, 2'b00);
      else chk("ready_outside_load", bus.req_ready, 0);
      if (!busy) chk("idle_core_reset", core_reset, 1);
      if (start_chk == 2) begin
         chk("after_start", {core_reset, core_enable}, 2'b01);
         start_chk = 0;
      end
      if (start_chk == 1) begin
         chk("start_pulse", {core_reset, busy, core_enable}, 3'b110);
         start_chk = 2;
      end
      if (expect_idle) begin
         chk("idle_after_timeout", busy, 0);
         expect_idle = 0;
      end
      if (err_timeout) begin
         err_cnt++;
         chk("timeout_cycle", run_cnt_m + 1, MAXC);
         chk("timeout_expected", no_done, 1);
         expect_idle = 1;
      end
      if (prev_hold) begin
         chk("hold_valid", bus.rsp_valid, 1);
         chk("hold_data", bus.rsp_data, prev_data);
         chk("hold_id", bus.rsp_id, prev_id);
      end
      // Drive inputs for the coming edge.
      gap_tog = ~gap_tog;
      for (int r = 0; r < NR; r++) begin
         if (req_q[r].size() > 0)
            bus.req_valid[r] = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? gap_tog : ($urandom_range(0, 3) != 0);
         else
            bus.req_valid[r] = 1'b0;
         bus.req_data[r] = bus.req_valid[r] ? req_q[r][0] : rnd_w();
      end
      if (rsp_mode == 1) bus.rsp_ready = ($urandom_range(0, 2) != 0);
      else if (rsp_mode == 2) bus.rsp_ready = (bp_hold == 0);
      else bus.rsp_ready = 1'b1;
      if (bp_hold > 0) bp_hold--;
      // Predict what the coming edge does.
      if (!busy) begin
         g = pick(bus.req_valid, ptr_m);
         if (g >= 0) begin
            grant_pend = 1;
            exp_grant = g;
         end
      end
      if (m_load && bus.req_valid[load_id]) begin
         load_w.push_back(req_q[load_id].pop_front());
         if (load_w.size() == SS) begin
            ptr_m = (load_id + 1) % NR;
            m_load = 0;
            start_chk = 1;
            if (!no_done)
               for (int i = 0; i < SS; i++)
                  exp_q.push_back('{data: load_w[i] + NB'(6), id: load_id, last: (i == SS - 1), idx: i});
            load_w.delete();
         end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
         rsp_log.push_back('{data: bus.rsp_data, id: int'(bus.rsp_id), last: bus.rsp_last, idx: 0});
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_last", bus.rsp_last, e.last);
            if (rsp_mode == 2 && e.idx == 0) bp_hold = 5;
         end
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_id   = bus.rsp_id;
   endtask

   function automatic bit all_idle();
      for (int r = 0; r < NR; r++) if (req_q[r].size() != 0) return 0;
      return !busy && exp_q.size() == 0 && !m_load && !grant_pend;
   endfunction

   task automatic drain(input int limit);
      for (int i = 0; i < limit; i++) begin
         cycle();
         if (all_idle()) return;
      end
      chk("drain_timeout", 0, 1);
   endtask

   function automatic int log_at(input int i);
      return (grant_log.size() > i) ? grant_log[i] : -1;
   endfunction

   initial begin
      int n0;
      reset_n = 1'b1;
      bus.req_valid = '0;
      bus.req_data = '0;
      bus.rsp_ready = 1'b0;
      gap_mode = 0; rsp_mode = 0; gap_tog = 0; err_cnt = 0; load_id = 0; exp_grant = 0;
      clear_model();
      #1;
      do_reset();

      // Round-robin across requesters 0,1,3.
      for (int k = 0; k < 2; k++) begin
         push_job(0, 0); push_job(1, 0); push_job(3, 0);
      end
      grant_log.delete();
      drain(600);
      chk("rr_grant0", log_at(0), 0);
      chk("rr_grant1", log_at(1), 1);
      chk("rr_grant2", log_at(2), 3);
      chk("rr_grant3", log_at(3), 0);

      // Single directed job from requester 2.
      done_delay = 14;
      n0 = rsp_log.size();
      push_job(2, 1);
      drain(200);
      chk("single_count", rsp_log.size() - n0, 3);
      if (rsp_log.size() >= n0 + 3) begin
         chk("single_w0", rsp_log[n0].data, 7);
         chk("single_w1", rsp_log[n0+1].data, 8);
         chk("single_w2", rsp_log[n0+2].data, 9);
         chk("single_id", rsp_log[n0+2].id, 2);
         chk("single_last0", rsp_log[n0].last, 0);
         chk("single_last2", rsp_log[n0+2].last, 1);
      end

      // Backpressure mid-unload.
      rsp_mode = 2; done_delay = 3;
      push_job(0, 0); push_job(1, 0);
      drain(400);
      rsp_mode = 0;

      // Watchdog: core never finishes.
      no_done = 1; err_cnt = 0;
      n0 = rsp_log.size();
      push_job(1, 0);
      drain(MAXC + 60);
      chk("timeout_pulses", err_cnt, 1);
      chk("timeout_no_rsp", rsp_log.size() - n0, 0);
      no_done = 0;

      // Reset while the core is running, then a clean job.
      done_delay = 14;
      push_job(3, 0);
      for (int i = 0; i < 60 && !core_enable; i++) cycle();
      chk("reached_run", core_enable, 1);
      repeat (3) cycle();
      do_reset();
      n0 = rsp_log.size();
      push_job(0, 0);
      drain(200);
      chk("post_reset_job", rsp_log.size() - n0, 3);

      // Gapped loading.
      gap_mode = 1; done_delay = 4;
      push_job(1, 0); push_job(2, 0);
      drain(400);

      // Randomized mix.
      gap_mode = 2; rsp_mode = 1;
      for (int round = 0; round < 4; round++) begin
         done_delay = $urandom_range(1, 20);
         for (int j = 0; j < 5; j++) push_job($urandom_range(0, NR - 1), 0);
         drain(1500);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
